// File: rtl/result_stream_agg.sv
// Burst reducer: collects BEATS consecutive signed beats, reduces them to
// sum/max/min and presents the result in a one-entry valid/ready slot tagged
// with a sequence number. Short bursts and results dropped on a full slot
// raise single-cycle error pulses.
module result_stream_agg #(
  parameter int BEATS = 4,
  parameter int DW    = 6,
  parameter int SW    = DW + $clog2(BEATS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] out_sum,
  output logic [DW-1:0] out_max,
  output logic [DW-1:0] out_min,
  output logic [3:0]    out_seq,
  output logic          err_short,
  output logic          err_drop
);

  localparam int CW = $clog2(BEATS + 1);

  typedef enum logic {IDLE, ACC} state_t;

  state_t               state, state_nx;
  logic [CW-1:0]        cnt;
  logic signed [SW-1:0] acc_sum, res_sum, beat_ext;
  logic signed [DW-1:0] acc_max, acc_min, res_max, res_min, beat;
  logic [3:0]           seq_cnt, seq_nx;
  logic                 start, step, done, short_burst;
  logic                 accept, load, drop;

  assign beat     = in_data;
  assign beat_ext = {{(SW-DW){in_data[DW-1]}}, in_data};

  // Running reduction including the current beat; becomes the result on the last beat.
  assign res_sum = acc_sum + beat_ext;
  assign res_max = (beat > acc_max) ? beat : acc_max;
  assign res_min = (beat < acc_min) ? beat : acc_min;

  // Slot handshake: a completion may reuse the slot if it is empty or drained on the same edge.
  assign accept = out_valid && out_ready;
  assign load   = done && (!out_valid || out_ready);
  assign drop   = done && out_valid && !out_ready;
  // Tag counts results accepted before this one, including an accept on this edge.
  assign seq_nx = seq_cnt + {3'b000, accept};

  // Collector state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Collector next state and per-cycle control strobes.
  always_comb begin
    state_nx    = state;
    start       = 1'b0;
    step        = 1'b0;
    done        = 1'b0;
    short_burst = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          start    = 1'b1;
          state_nx = ACC;
        end
      end
      ACC: begin
        if (in_valid) begin
          step = 1'b1;
          if (cnt == CW'(BEATS - 1)) begin
            done     = 1'b1;
            state_nx = IDLE;
          end
        end else begin
          short_burst = 1'b1;
          state_nx    = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Accumulators and beat counter; a new burst reloads them from the first beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc_sum <= '0;
      acc_max <= '0;
      acc_min <= '0;
    end else if (start) begin
      cnt     <= CW'(1);
      acc_sum <= beat_ext;
      acc_max <= beat;
      acc_min <= beat;
    end else if (step) begin
      cnt     <= done ? '0 : cnt + CW'(1);
      acc_sum <= res_sum;
      acc_max <= res_max;
      acc_min <= res_min;
    end else if (short_burst) begin
      cnt     <= '0;
    end
  end

  // Output slot, sequence counter and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_max   <= '0;
      out_min   <= '0;
      out_seq   <= '0;
      seq_cnt   <= '0;
      err_short <= 1'b0;
      err_drop  <= 1'b0;
    end else begin
      err_short <= short_burst;
      err_drop  <= drop;
      seq_cnt   <= seq_nx;
      if (load) begin
        out_valid <= 1'b1;
        out_sum   <= res_sum;
        out_max   <= res_max;
        out_min   <= res_min;
        out_seq   <= seq_nx;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_result_stream_agg.sv
// Self-checking bench for result_stream_agg: directed scenarios plus a
// randomized run, all compared against a burst-level reference model.
module tb_result_stream_agg;

  localparam int BEATS = 4;
  localparam int DW    = 6;
  localparam int SW    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [SW-1:0] out_sum;
  logic [DW-1:0] out_max, out_min;
  logic [3:0]    out_seq;
  logic          err_short, err_drop;

  int nchk = 0;
  int nerr = 0;

  result_stream_agg #(.BEATS(BEATS), .DW(DW), .SW(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_max(out_max), .out_min(out_min), .out_seq(out_seq),
    .err_short(err_short), .err_drop(err_drop)
  );

  always #5 clk = ~clk;

  // Reference model: the open burst as a list of beats, the slot as plain fields.
  int bq[$];
  bit m_valid, m_short, m_drop;
  int m_sum, m_max, m_min, m_seq, m_seqc;

  task automatic mdl_clear();
    bq.delete();
    m_valid = 0; m_short = 0; m_drop = 0;
    m_sum = 0; m_max = 0; m_min = 0; m_seq = 0; m_seqc = 0;
  endtask

  // Apply one cycle of inputs, advance the model across the edge, settle 1 time unit after.
  task automatic drive(input bit v, input int d, input bit r);
    bit comp, acc;
    int s, mx, mn;
    comp = 0; s = 0; mx = 0; mn = 0;
    in_valid = v; in_data = DW'(d); out_ready = r;
    @(posedge clk);
    m_short = 0; m_drop = 0;
    if (bq.size() > 0 && !v) begin
      m_short = 1;
      bq.delete();
    end else if (v) begin
      bq.push_back(d);
      if (bq.size() == BEATS) begin
        comp = 1; mx = bq[0]; mn = bq[0];
        foreach (bq[i]) begin
          s += bq[i];
          if (bq[i] > mx) mx = bq[i];
          if (bq[i] < mn) mn = bq[i];
        end
        bq.delete();
      end
    end
    acc = m_valid && r;
    if (acc) m_seqc = (m_seqc + 1) % 16;
    if (comp) begin
      if (!m_valid || r) begin
        m_valid = 1; m_sum = s; m_max = mx; m_min = mn; m_seq = m_seqc;
      end else m_drop = 1;
    end else if (acc) m_valid = 0;
    #1;
  endtask

  task automatic do_reset();
    in_valid = 0; in_data = '0; out_ready = 0;
    rst_n = 0;
    mdl_clear();
    #3;
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    mdl_clear();
    #1;
    nchk += 6;
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %0d want 0", out_valid); end
    if (out_sum !== '0) begin nerr++; $display("FAIL reset_sum: got %0d want 0", out_sum); end
    if (out_max !== '0 || out_min !== '0) begin nerr++; $display("FAIL reset_maxmin: got %0d/%0d want 0/0", out_max, out_min); end
    if (out_seq !== '0) begin nerr++; $display("FAIL reset_seq: got %0d want 0", out_seq); end
    if (err_short !== 1'b0) begin nerr++; $display("FAIL reset_err_short: got %0d want 0", err_short); end
    if (err_drop !== 1'b0) begin nerr++; $display("FAIL reset_err_drop: got %0d want 0", err_drop); end
    #3;
    rst_n = 1;
  endtask

  task automatic test_basic();
    int b[4] = '{3, -5, 7, -1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, b[i], 1);
      nchk++;
      if (out_valid !== (i == 3)) begin nerr++; $display("FAIL basic_valid_beat%0d: got %0d want %0d", i, out_valid, i == 3); end
    end
    nchk += 4;
    if (out_sum !== SW'(4)) begin nerr++; $display("FAIL basic_sum: got %0d want %0d", $signed(out_sum), 4); end
    if (out_max !== DW'(7)) begin nerr++; $display("FAIL basic_max: got %0d want 7", $signed(out_max)); end
    if (out_min !== DW'(-5)) begin nerr++; $display("FAIL basic_min: got %0d want -5", $signed(out_min)); end
    if (out_seq !== 4'd0) begin nerr++; $display("FAIL basic_seq: got %0d want 0", out_seq); end
    drive(0, 0, 1);
    nchk++;
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL basic_drain: got %0d want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 1, 0);
    drive(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 2, 0);
      nchk += 2;
      if (out_valid !== 1'b1 || out_sum !== SW'(4)) begin nerr++; $display("FAIL bp_hold: got v=%0d sum=%0d want v=1 sum=4", out_valid, $signed(out_sum)); end
      if (err_drop !== (i == 3)) begin nerr++; $display("FAIL bp_drop_beat%0d: got %0d want %0d", i, err_drop, i == 3); end
    end
    drive(0, 0, 0);
    nchk++;
    if (err_drop !== 1'b0) begin nerr++; $display("FAIL bp_drop_width: got %0d want 0", err_drop); end
    drive(0, 0, 1);
    nchk++;
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL bp_accept: got %0d want 0", out_valid); end
    // the next result must carry tag 1 because A was accepted
    for (int i = 0; i < 4; i++) drive(1, 0, 0);
    nchk++;
    if (out_seq !== 4'd1) begin nerr++; $display("FAIL bp_seq_after: got %0d want 1", out_seq); end
  endtask

  task automatic test_same_edge();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 1, 0);
    for (int i = 0; i < 4; i++) drive(1, 2, i == 3);
    nchk += 4;
    if (out_valid !== 1'b1) begin nerr++; $display("FAIL same_valid: got %0d want 1", out_valid); end
    if (out_sum !== SW'(8)) begin nerr++; $display("FAIL same_sum: got %0d want 8", $signed(out_sum)); end
    if (out_seq !== 4'd1) begin nerr++; $display("FAIL same_seq: got %0d want 1", out_seq); end
    if (err_drop !== 1'b0) begin nerr++; $display("FAIL same_drop: got %0d want 0", err_drop); end
  endtask

  task automatic test_short();
    do_reset();
    drive(1, 9, 1);
    drive(1, 9, 1);
    drive(0, 0, 1);
    nchk += 2;
    if (err_short !== 1'b1) begin nerr++; $display("FAIL short_pulse: got %0d want 1", err_short); end
    if (out_valid !== 1'b0) begin nerr++; $display("FAIL short_valid: got %0d want 0", out_valid); end
    drive(0, 0, 1);
    nchk++;
    if (err_short !== 1'b0) begin nerr++; $display("FAIL short_width: got %0d want 0", err_short); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, i, 1);
      if (i == 3) begin
        nchk++;
        if (out_valid !== 1'b1 || out_sum !== SW'(6) || out_max !== DW'(3) || out_min !== DW'(0))
          begin nerr++; $display("FAIL b2b_first: got v=%0d sum=%0d max=%0d min=%0d want 1/6/3/0", out_valid, $signed(out_sum), $signed(out_max), $signed(out_min)); end
      end
    end
    nchk++;
    if (out_valid !== 1'b1 || out_sum !== SW'(22) || out_max !== DW'(7) || out_min !== DW'(4) || out_seq !== 4'd1)
      begin nerr++; $display("FAIL b2b_second: got v=%0d sum=%0d max=%0d min=%0d seq=%0d want 1/22/7/4/1", out_valid, $signed(out_sum), $signed(out_max), $signed(out_min), out_seq); end
    nchk++;
    if (err_short !== 1'b0) begin nerr++; $display("FAIL b2b_no_short: got %0d want 0", err_short); end
  endtask

  task automatic test_extremes();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, -32, 1);
    nchk++;
    if (out_sum !== SW'(-128) || out_min !== DW'(-32)) begin nerr++; $display("FAIL ext_neg: got sum=%0d min=%0d want -128/-32", $signed(out_sum), $signed(out_min)); end
    for (int i = 0; i < 4; i++) drive(1, 31, 1);
    nchk++;
    if (out_sum !== SW'(124) || out_max !== DW'(31)) begin nerr++; $display("FAIL ext_pos: got sum=%0d max=%0d want 124/31", $signed(out_sum), $signed(out_max)); end
  endtask

  task automatic test_seq_wrap();
    do_reset();
    for (int n = 0; n < 17; n++) begin
      for (int i = 0; i < 4; i++) drive(1, n, 1);
      nchk++;
      if (out_seq !== 4'(n % 16)) begin nerr++; $display("FAIL seq_wrap_%0d: got %0d want %0d", n, out_seq, n % 16); end
    end
  endtask

  task automatic test_reset_mid();
    int b[4] = '{-1, -2, -3, -4};
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 3, 0);
    drive(1, 5, 0);
    drive(1, 5, 0);
    #1;
    rst_n = 0;
    mdl_clear();
    #1;
    nchk++;
    if (out_valid !== 0 || out_sum !== '0 || out_max !== '0 || out_min !== '0 || out_seq !== '0 || err_short !== 0 || err_drop !== 0)
      begin nerr++; $display("FAIL rstmid_clear: got v=%0d sum=%0d max=%0d min=%0d seq=%0d es=%0d ed=%0d want all 0", out_valid, out_sum, out_max, out_min, out_seq, err_short, err_drop); end
    in_valid = 0; out_ready = 0;
    #1;
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      drive(1, b[i], 1);
      nchk++;
      if (err_short !== 1'b0 || err_drop !== 1'b0) begin nerr++; $display("FAIL rstmid_pulse%0d: got es=%0d ed=%0d want 0/0", i, err_short, err_drop); end
    end
    nchk++;
    if (out_valid !== 1'b1 || out_sum !== SW'(-10) || out_max !== DW'(-1) || out_min !== DW'(-4) || out_seq !== 4'd0)
      begin nerr++; $display("FAIL rstmid_after: got v=%0d sum=%0d max=%0d min=%0d seq=%0d want 1/-10/-1/-4/0", out_valid, $signed(out_sum), $signed(out_max), $signed(out_min), out_seq); end
  endtask

  task automatic test_random();
    bit v, r;
    int d;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      v = ($urandom_range(0, 9) < 8);
      d = int'($urandom_range(0, 63)) - 32;
      r = ($urandom_range(0, 2) != 0);
      drive(v, d, r);
      nchk += 3;
      if (out_valid !== m_valid) begin nerr++; $display("FAIL rnd_valid@%0d: got %0d want %0d", c, out_valid, m_valid); end
      if (err_short !== m_short || err_drop !== m_drop) begin nerr++; $display("FAIL rnd_err@%0d: got es=%0d ed=%0d want %0d/%0d", c, err_short, err_drop, m_short, m_drop); end
      if (m_valid && (out_sum !== SW'(m_sum) || out_max !== DW'(m_max) || out_min !== DW'(m_min) || out_seq !== 4'(m_seq)))
        begin nerr++; $display("FAIL rnd_data@%0d: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", c, $signed(out_sum), $signed(out_max), $signed(out_min), out_seq, m_sum, m_max, m_min, m_seq); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_same_edge();
    test_short();
    test_back_to_back();
    test_extremes();
    test_seq_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
